// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: data width, funct3 encodings and muldiv FSM states.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        F3Mul    = 3'b000,
        F3Mulh   = 3'b001,
        F3Mulhsu = 3'b010,
        F3Mulhu  = 3'b011,
        F3Div    = 3'b100,
        F3Divu   = 3'b101,
        F3Rem    = 3'b110,
        F3Remu   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// One restoring shift-subtract divide step on unsigned magnitudes.
module muldiv_div_core
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        ge      = (shifted >= {1'b0, divisor_i});
        // The true difference is below the divisor, so the low bits are exact.
        diff    = shifted[XLEN-1:0] - divisor_i;
        rem_o   = ge ? diff : shifted[XLEN-1:0];
        quo_o   = {quo_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle on operand magnitudes.
// Divide ops are built only with MULDIV_DIV_EN defined; otherwise they return 0.
module muldiv_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    md_state_e         state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d, prod;
    logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d, res_fix;
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_q, rd_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              neg_q, neg_d;

    logic              sgn_a, sgn_b, sa, sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;

`ifdef MULDIV_DIV_EN
    logic              sa_q, sa_d, spec_q, spec_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d, div_rem, div_quo;
    logic              div_zero, div_ovf;

    muldiv_div_core u_div_core (
        .rem_i     (acc_q[2*XLEN-1:XLEN]),
        .quo_i     (acc_q[XLEN-1:0]),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );
`endif

    always_comb begin
        sgn_a = (funct3 == F3Mulh) || (funct3 == F3Mulhsu) || (funct3 == F3Div) ||
                (funct3 == F3Rem);
        sgn_b = (funct3 == F3Mulh) || (funct3 == F3Div) || (funct3 == F3Rem);
        sa    = sgn_a & rs1_data[XLEN-1];
        sb    = sgn_b & rs2_data[XLEN-1];
        mag_a = sa ? (~rs1_data + 32'd1) : rs1_data;
        mag_b = sb ? (~rs2_data + 32'd1) : rs2_data;
`ifdef MULDIV_DIV_EN
        div_zero = (rs2_data == '0);
        div_ovf  = ((funct3 == F3Div) || (funct3 == F3Rem)) &&
                   (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
`endif
        // Shift-add step: multiplier sits in the low half and shifts out as the product grows.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    end

    always_comb begin
        prod    = neg_q ? (~acc_q + 64'd1) : acc_q;
        res_fix = '0;
        if (!f3_q[2]) begin
            res_fix = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
`ifdef MULDIV_DIV_EN
        else if (spec_q) begin
            res_fix = spec_res_q;
        end else if (f3_q[1]) begin
            res_fix = sa_q ? (~acc_q[2*XLEN-1:XLEN] + 32'd1) : acc_q[2*XLEN-1:XLEN];
        end else begin
            res_fix = neg_q ? (~acc_q[XLEN-1:0] + 32'd1) : acc_q[XLEN-1:0];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        res_d   = res_q;
`ifdef MULDIV_DIV_EN
        sa_d       = sa_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    f3_d  = funct3;
                    rd_d  = rd_in;
                    cnt_d = '0;
                    neg_d = sa ^ sb;
                    if (funct3[2]) begin
                        state_d = StDiv;
                        acc_d   = {32'd0, mag_a};
                        opb_d   = mag_b;
`ifdef MULDIV_DIV_EN
                        sa_d       = sa;
                        spec_d     = div_zero | div_ovf;
                        spec_res_d = div_zero ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                                              : (funct3[1] ? 32'd0 : 32'h8000_0000);
`endif
                    end else begin
                        state_d = StMul;
                        acc_d   = {32'd0, mag_b};
                        opb_d   = mag_a;
                    end
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = StDone;
            end
            StDiv: begin
`ifdef MULDIV_DIV_EN
                if (spec_q) begin
                    state_d = StDone;
                end else begin
                    acc_d = {div_rem, div_quo};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_d = StDone;
                end
`else
                state_d = StDone;
`endif
            end
            StDone: begin
                state_d = StIdle;
                res_d   = res_fix;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            opb_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
`ifdef MULDIV_DIV_EN
            sa_q       <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
`ifdef MULDIV_DIV_EN
            sa_q       <= sa_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
`endif
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    // The sign-fixed value is visible during the done pulse and held afterwards.
    assign result = done ? res_fix : res_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed/scoreboard testbench for muldiv_unit; divide expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  rd_exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            default: begin
                if (!DivEn) return 32'd0;
                if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
                if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return f3[1] ? 32'd0 : 32'h8000_0000;
                case (f3[1:0])
                    2'b00:   return $signed(a) / $signed(b);
                    2'b01:   return a / b;
                    2'b10:   return $signed(a) % $signed(b);
                    default: return a % b;
                endcase
            end
        endcase
    endfunction

    // Cycles from accept to the done pulse (T+n).
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!f3[2]) return 33;
        if (!DivEn) return 2;
        if (b == 32'd0) return 2;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input bit poke_busy, input bit poke_done);
        int          j;
        int          lat;
        bit          busy_ok;
        logic [31:0] e;
        logic [4:0]  er;
        lat = exp_lat(f3, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
        exp_q.push_back(exp);
        rd_exp_q.push_back(rd);
        @(negedge clk);
        start = 1'b0; funct3 = ~f3; rs1_data = $urandom; rs2_data = $urandom; rd_in = ~rd;
        j = 1;
        busy_ok = 1'b1;
        while (!done && j < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (poke_busy && j == 3) begin
                start = 1'b1; funct3 = 3'b011; rd_in = 5'd9;
            end else if (j == 4) begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " latency"}, 32'(j), 32'(lat));
        check({tag, " busy@done"}, {31'd0, busy}, 32'd1);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            er = rd_exp_q.pop_front();
            check({tag, " result"}, result, e);
            check({tag, " rd_out"}, {27'd0, rd_out}, {27'd0, er});
        end else begin
            e = 32'd0;
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end
        if (poke_done) begin
            start = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, " held"}, result, e);
    endtask

    initial begin
        int          dpulse;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        @(negedge clk);
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        reset = 1'b0;

        run_op("MUL 7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0, 0);
        run_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFE, 0, 0);
        run_op("MULH", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, 1, 0);
        run_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 0, 1);
        run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, DivEn ? 32'hFFFF_FFFD : 32'd0, 0, 0);
        run_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, DivEn ? 32'hFFFF_FFFF : 32'd0, 0, 0);
        run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd3, DivEn ? 32'd14 : 32'd0, 1, 0);
        run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd4, DivEn ? 32'd2 : 32'd0, 0, 0);
        run_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 5'd6, DivEn ? 32'hFFFF_FFFF : 32'd0, 0, 0);
        run_op("REM 5/0", 3'd6, 32'd5, 32'd0, 5'd8, DivEn ? 32'd5 : 32'd0, 0, 1);
        run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10,
               DivEn ? 32'h8000_0000 : 32'd0, 0, 0);
        run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom;
            run_op($sformatf("rand%0d f3=%0d", i, rf), rf, ra, rb, 5'(i + 12),
                   model(rf, ra, rb), 0, 0);
        end

        // Abort a multiply at T+10 and launch a new op at T+12.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd20;
        exp_q.push_back(32'd81);
        rd_exp_q.push_back(5'd20);
        dpulse = 0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            if (done) dpulse++;
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        exp_q.delete();
        rd_exp_q.delete();
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        if (done) dpulse++;
        reset = 1'b0;
        check("abort no done", 32'(dpulse), 32'd0);
        run_op("MUL after abort", 3'd0, 32'd12345, 32'd678, 5'd21, 32'd8369910, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port start, input, 1, launch request; accepted only when busy=0.
REQ-004 SHALL have port funct3, input, 3, RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port rs1_data, input, 32, operand A, driven by register-file read_data1.
REQ-006 SHALL have port rs2_data, input, 32, operand B, driven by register-file read_data2.
REQ-007 SHALL have port rd_in, input, 5, destination register index.
REQ-008 SHALL have port busy, output, 1, operation in flight; core stalls PC while high.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse; gates reg_write.
REQ-010 SHALL have port result, output, 32, to register-file write_data; held until next done.
REQ-011 SHALL have port rd_out, output, 5, latched rd_in of completing op.

Function
REQ-012 SHALL implement FSM IDLE, MUL, DIV, DONE; start in IDLE moves to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-013 SHALL latch funct3, rd_in, operands on accept edge; later input changes SHALL NOT affect op.
REQ-014 SHALL convert signed operands to magnitudes on accept: MULH both signed, MULHSU rs1 only, DIV/REM both; others unsigned.
REQ-015 SHALL iterate 1 bit/cycle for 32 cycles: shift-add (64-bit product) in MUL, restoring shift-subtract in DIV; 6-bit iteration counter.
REQ-016 SHALL, for start accepted in cycle T, assert busy in T+1..T+33 and done only in T+33 (DONE state); IDLE at T+34.
REQ-017 SHALL apply sign fix in DONE: product negated if operand signs differ; quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
REQ-018 SHALL select result: MUL low 32 bits, MULH/MULHSU/MULHU high 32, DIV/DIVU quotient, REM/REMU remainder.
REQ-019 SHALL on divisor zero skip iterations (done at T+2): DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> rs1_data.
REQ-020 SHALL on DIV overflow (0x80000000 / 0xFFFFFFFF) skip iterations (done at T+2): DIV -> 0x80000000, REM -> 0.
REQ-021 SHALL ignore start while busy=1, including the DONE cycle; no queuing.
REQ-022 SHALL pass rd_out=0 unchanged; register file discards writes to x0.

Reset
REQ-023 SHALL on reset, any cycle incl. mid-operation, abort op, enter IDLE, clear busy, done, result, rd_out, counter, datapath to 0.
REQ-024 SHALL accept start in first cycle after reset deasserts.

Configuration
REQ-025 SHALL, with MULDIV_DIV_EN defined, implement DIV state and all divide ops per REQ-015..020.
REQ-026 SHALL, without MULDIV_DIV_EN, omit divider logic; funct3[2]=1 completes at T+2 with result=0.

Structure
REQ-027 SHALL place funct3 encodings, FSM state encoding, XLEN=32 in shared package riscv_pkg.
REQ-028 SHALL place divider iteration datapath in sub-module muldiv_div_core, instantiated only under MULDIV_DIV_EN.

Verification
REQ-029 SHALL check MUL 7 x -3 (0xFFFFFFFD) -> result 0xFFFFFFEB, done exactly at T+33, busy T+1..T+33.
REQ-030 SHALL check MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-031 SHALL check DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DIVU 100/7 -> 14, REMU -> 2.
REQ-032 SHALL check DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, all done at T+2.
REQ-033 SHALL check second start during busy ignored, and reset at T+10 -> busy=0, done never pulses, new op at T+12 correct.
